// File: rtl/phoneme_pkg.sv
// Shared definitions for the phoneme player: defaults, address width, FSM
// encoding and the contents of the phoneme address table.
package phoneme_pkg;

  localparam int DEF_NUM_PHONEMES  = 64;
  localparam int DEF_FLASH_TIMEOUT = 255;
  localparam int ADDR_W            = 23;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_FETCH   = 3'd2,
    ST_PLAY_LO = 3'd3,
    ST_PLAY_HI = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  typedef struct packed {
    addr_t start_addr;
    addr_t end_addr;
  } addr_range_t;

  // Entry n starts at (n+1)*64 and spans code[2:1]+1 words; entry 63 straddles
  // the top of the address space so playback exercises address wrap.
  function automatic addr_range_t rom_entry(input logic [7:0] code);
    addr_range_t r;
    if (code == 8'd63) begin
      r.start_addr = 23'h7F_FFFF;
      r.end_addr   = 23'h00_0001;
    end else begin
      r.start_addr = addr_t'({code, 6'b0}) + addr_t'(64);
      r.end_addr   = r.start_addr + addr_t'(code[2:1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/phoneme_addr_rom.sv
// Phoneme code to inclusive flash word range, registered once.
module phoneme_addr_rom
  import phoneme_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        code,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr
);

  addr_range_t entry;

  always_comb begin
    entry = rom_entry(code);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_addr <= '0;
      end_addr   <= '0;
    end else begin
      start_addr <= entry.start_addr;
      end_addr   <= entry.end_addr;
    end
  end

endmodule

// File: rtl/phoneme_player.sv
// Plays one phoneme: looks up its flash word range, fetches each 32-bit word
// and emits its low then high 16-bit half on successive sample ticks.
module phoneme_player
  import phoneme_pkg::*;
#(
  parameter int NUM_PHONEMES  = DEF_NUM_PHONEMES,
  parameter int FLASH_TIMEOUT = DEF_FLASH_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        phoneme_selection,
  input  logic              fsm_start_signal,
  output logic              fsm_finish_signal,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic [31:0]       flash_data,
  input  logic              flash_data_valid,
  output logic [15:0]       audio_sample,
  output logic              audio_valid,
  output logic              flash_error
);

  localparam int TW = $clog2(FLASH_TIMEOUT + 1);

  state_t          state;
  logic            start_prev;
  logic            start_armed;
  logic            start_edge;
  logic [TW-1:0]   tmo_cnt;
  addr_t           cur_addr;
  addr_t           end_addr_q;
  addr_t           rom_start;
  addr_t           rom_end;
  logic [31:0]     data_q;

  // The ROM registers the live selection every cycle, so its output during
  // LOOKUP is the code captured on the start edge.
  phoneme_addr_rom u_rom (
    .clk        (clk),
    .reset_n    (reset_n),
    .code       (phoneme_selection),
    .start_addr (rom_start),
    .end_addr   (rom_end)
  );

  // Edges are only accepted once start has been seen low after reset.
  assign start_edge = fsm_start_signal & ~start_prev & start_armed;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= ST_IDLE;
      start_prev        <= 1'b0;
      start_armed       <= 1'b0;
      tmo_cnt           <= '0;
      cur_addr          <= '0;
      end_addr_q        <= '0;
      data_q            <= '0;
      flash_read        <= 1'b0;
      flash_addr        <= '0;
      audio_sample      <= '0;
      audio_valid       <= 1'b0;
      fsm_finish_signal <= 1'b0;
      flash_error       <= 1'b0;
    end else begin
      start_prev  <= fsm_start_signal;
      audio_valid <= 1'b0;
      if (!fsm_start_signal) start_armed <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            fsm_finish_signal <= 1'b0;
            flash_error       <= 1'b0;
            state <= (int'(phoneme_selection) >= NUM_PHONEMES) ? ST_DONE : ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          cur_addr   <= rom_start;
          end_addr_q <= rom_end;
          flash_addr <= rom_start;
          flash_read <= 1'b1;
          tmo_cnt    <= '0;
          state      <= ST_FETCH;
        end
        ST_FETCH: begin
          if (flash_data_valid) begin
            data_q     <= flash_data;
            flash_read <= 1'b0;
            state      <= ST_PLAY_LO;
          end else if (tmo_cnt == TW'(FLASH_TIMEOUT - 1)) begin
            flash_read  <= 1'b0;
            flash_error <= 1'b1;
            state       <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_PLAY_LO: begin
          if (sample_tick) begin
            audio_sample <= data_q[15:0];
            audio_valid  <= 1'b1;
            state        <= ST_PLAY_HI;
          end
        end
        ST_PLAY_HI: begin
          if (sample_tick) begin
            audio_sample <= data_q[31:16];
            audio_valid  <= 1'b1;
            if (cur_addr == end_addr_q) begin
              state <= ST_DONE;
            end else begin
              cur_addr   <= cur_addr + addr_t'(1);
              flash_addr <= cur_addr + addr_t'(1);
              flash_read <= 1'b1;
              tmo_cnt    <= '0;
              state      <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          audio_sample      <= '0;
          fsm_finish_signal <= 1'b1;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/phoneme_player.md
PHONEME_PLAYER -- requirements
Module: phoneme_player

Interface
REQ-001 SHALL have parameter NUM_PHONEMES, default 64, meaning the count of valid phoneme codes (0..NUM_PHONEMES-1).
REQ-002 SHALL have parameter FLASH_TIMEOUT, default 255, meaning the max cycles to wait for flash_data_valid.
REQ-003 SHALL have ports clk input 1, the single clock; reset_n input 1, asynchronous active-low reset.
REQ-004 SHALL have port phoneme_selection input 8, the phoneme code from the PicoBlaze output port.
REQ-005 SHALL have port fsm_start_signal input 1, a level from PicoBlaze; its rising edge requests playback.
REQ-006 SHALL have port fsm_finish_signal output 1, a done level polled by PicoBlaze.
REQ-007 SHALL have port sample_tick input 1, a one-cycle audio-rate strobe.
REQ-008 SHALL have ports flash_read output 1, flash_addr output 23 (word address), flash_data input 32, flash_data_valid input 1.
REQ-009 SHALL have ports audio_sample output 16 (signed), audio_valid output 1 (one-cycle pulse), flash_error output 1 (sticky timeout flag).

Function
REQ-010 SHALL detect start as fsm_start_signal high with its registered previous value low; one detection per edge.
REQ-011 SHALL implement states IDLE, LOOKUP, FETCH, PLAY_LO, PLAY_HI, DONE.
REQ-012 IDLE: on a start edge, capture phoneme_selection, clear fsm_finish_signal, then go to LOOKUP; if the code is >= NUM_PHONEMES, go to DONE instead, with no flash access.
REQ-013 LOOKUP: take the inclusive word range start_addr/end_addr from the table (1-cycle registered latency), load cur_addr=start_addr, then go to FETCH.
REQ-014 FETCH: drive flash_addr=cur_addr and hold flash_read high until flash_data_valid.
REQ-015 FETCH: in the cycle flash_data_valid is high, capture flash_data, drop flash_read in the next cycle, and go to PLAY_LO.
REQ-016 FETCH: if FLASH_TIMEOUT cycles elapse without flash_data_valid, drop flash_read, set flash_error, and go to DONE.
REQ-017 PLAY_LO: on sample_tick, output data[15:0] on audio_sample with audio_valid high for one cycle, then go to PLAY_HI.
REQ-018 PLAY_HI: on sample_tick, output data[31:16] with audio_valid high for one cycle.
REQ-019 PLAY_HI exit: if cur_addr==end_addr, go to DONE; otherwise cur_addr+1 (23-bit, wraps modulo 2^23) and go to FETCH.
REQ-020 audio_sample SHALL change only with audio_valid.
REQ-021 audio_sample SHALL be forced to 0 in the cycle DONE is entered (silence).
REQ-022 DONE SHALL set fsm_finish_signal high and go to IDLE next cycle; fsm_finish_signal stays high until the next start edge.
REQ-023 Start edges outside IDLE SHALL be ignored (no restart, no queueing).
REQ-024 A start edge in the same cycle as a DONE transition SHALL be ignored; PicoBlaze must toggle start again.
REQ-025 A sample_tick arriving in FETCH or LOOKUP SHALL be dropped (no backlog); audio_valid stays low.
REQ-026 flash_error SHALL be cleared only by reset or the next accepted start edge.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, flash_read=0, flash_addr=0, audio_sample=0, audio_valid=0, fsm_finish_signal=0, flash_error=0, timeout counter=0, start-edge register=0.
REQ-028 Reset mid-fetch SHALL abandon the flash transaction; a late flash_data_valid in IDLE SHALL be ignored.
REQ-029 After reset release with fsm_start_signal already high, no start SHALL be detected until it falls and rises again.

Structure
REQ-030 State encoding, NUM_PHONEMES, FLASH_TIMEOUT default and the 23-bit address width SHALL live in a shared package phoneme_pkg.
REQ-031 The phoneme address table SHALL be a sub-module phoneme_addr_rom (code in, registered start_addr/end_addr out).

Verification
REQ-032 Reset, raise start with code 3 whose table entry is 0x100..0x101, data 0x2222_1111 then 0x4444_3333, one tick every 50 cycles -> samples 0x1111, 0x2222, 0x3333, 0x4444 in order, then fsm_finish_signal=1.
REQ-033 Raise start with code 0x80 -> fsm_finish_signal=1 within 3 cycles, flash_read never asserted.
REQ-034 Withhold flash_data_valid -> flash_read drops after 255 cycles, flash_error=1, fsm_finish_signal=1, audio_sample=0.
REQ-035 Pulse start again mid-playback of a 4-word phoneme -> all 8 samples still emitted once, single finish.
REQ-036 Assert reset_n low during FETCH, then return valid -> state IDLE, no audio_valid, and the next start plays correctly from start_addr.
